mux_rr_scheduler: RTL and testbench

Four-lane round-robin scheduler sitting in front of the level-2 output of the mux tree. It arbitrates lanes 0-3, each an 8-bit data word with a valid, onto the single data_out_l2/valid_out_l2 stream. It uses per-lane ready backpressure, bounded bursts and a registered output stage. It lets the two-level mux datapath be shared fairly when several lanes are valid at once.

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_rr_scheduler_if.sv | 32 +++
 rtl/rr_pick4.sv | 24 ++
 rtl/mux_rr_scheduler.sv | 116 +++++++++++
 tb/tb_mux_rr_scheduler.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared types and constants for the four-lane round-robin scheduler.
package mux_pkg;

    localparam int DATA_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef logic [LANE_W-1:0] lane_t;

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Lane inputs, per-lane ready and the level-2 output stream of the scheduler.
interface mux_rr_scheduler_if import mux_pkg::*; #(
    parameter int DATA_W = mux_pkg::DATA_W
);

    logic              valid0, valid1, valid2, valid3;
    logic [DATA_W-1:0] data_in0, data_in1, data_in2, data_in3;
    logic [3:0]        lane_en;
    logic              ready_in;
    logic              ready0, ready1, ready2, ready3;
    logic [DATA_W-1:0] data_out_l2;
    logic              valid_out_l2;
    lane_t             grant;
    logic              busy;

    modport slave (
        input  valid0, valid1, valid2, valid3,
        input  data_in0, data_in1, data_in2, data_in3,
        input  lane_en, ready_in,
        output ready0, ready1, ready2, ready3,
        output data_out_l2, valid_out_l2, grant, busy
    );

    modport master (
        output valid0, valid1, valid2, valid3,
        output data_in0, data_in1, data_in2, data_in3,
        output lane_en, ready_in,
        input  ready0, ready1, ready2, ready3,
        input  data_out_l2, valid_out_l2, grant, busy
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin pick: first requester at or after ptr, wrapping 3->0.
module rr_pick4 import mux_pkg::*; (
    input  logic [3:0] req,
    input  lane_t      ptr,
    output logic       found,
    output lane_t      idx
);

    lane_t lane;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        lane  = '0;
        for (int i = 0; i < 4; i++) begin
            lane = ptr + LANE_W'(i);
            if (!found && req[lane]) begin
                found = 1'b1;
                idx   = lane;
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler: arbitrates four lanes onto one registered output with bounded bursts.
module mux_rr_scheduler import mux_pkg::*; #(
    parameter int DATA_W    = mux_pkg::DATA_W,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input logic                clk,
    input logic                reset_L,
    mux_rr_scheduler_if.slave  bus
);

    state_t            state, state_nxt;
    lane_t             grant_q, grant_nxt;
    lane_t             rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]  burst_cnt, burst_nxt;
    logic [DATA_W-1:0] data_q, data_sel;
    logic              vld_q;

    logic [3:0] valid_vec, cand, ready_vec;
    logic       out_load, lane_live, xfer, found;
    lane_t      pick;

    assign valid_vec = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};
    assign cand      = valid_vec & bus.lane_en;
    assign out_load  = !vld_q || bus.ready_in;
    assign lane_live = valid_vec[grant_q] && bus.lane_en[grant_q];

    // Ready is a function of registered state and ready_in only, never of the lane valid.
    always_comb begin
        ready_vec = '0;
        if (state == GRANT && bus.lane_en[grant_q] && out_load)
            ready_vec[grant_q] = 1'b1;
    end

    assign xfer = lane_live && ready_vec[grant_q];

    always_comb begin
        data_sel = bus.data_in0;
        case (grant_q)
            2'd1:    data_sel = bus.data_in1;
            2'd2:    data_sel = bus.data_in2;
            2'd3:    data_sel = bus.data_in3;
            default: data_sel = bus.data_in0;
        endcase
    end

    rr_pick4 u_pick (
        .req   (cand),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (pick)
    );

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_q;
        rr_ptr_nxt = rr_ptr;
        burst_nxt  = burst_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = pick;
                    burst_nxt = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!lane_live) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = grant_q + 2'd1;
                end else if (xfer) begin
                    if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = grant_q + 2'd1;
                        burst_nxt  = '0;
                    end else begin
                        burst_nxt = burst_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            grant_q   <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_q   <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_nxt;
            if (xfer) begin
                data_q <= data_sel;
                vld_q  <= 1'b1;
            end else if (bus.ready_in) begin
                vld_q  <= 1'b0;
            end
        end
    end

    assign bus.ready0       = ready_vec[0];
    assign bus.ready1       = ready_vec[1];
    assign bus.ready2       = ready_vec[2];
    assign bus.ready3       = ready_vec[3];
    assign bus.data_out_l2  = data_q;
    assign bus.valid_out_l2 = vld_q;
    assign bus.grant        = grant_q;
    assign bus.busy         = (state == GRANT);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler with hand-computed expectations.
module tb_mux_rr_scheduler;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mux_rr_scheduler_if ifc ();

    mux_rr_scheduler #(.DATA_W(8), .MAX_BURST(4), .CNT_W(4)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rdy();
        return {ifc.ready3, ifc.ready2, ifc.ready1, ifc.ready0};
    endfunction

    function automatic logic [7:0] word(input int lane);
        return 8'hA0 + 8'(lane);
    endfunction

    task automatic set_valid(input logic [3:0] v);
        {ifc.valid3, ifc.valid2, ifc.valid1, ifc.valid0} = v;
    endtask

    task automatic set_words();
        ifc.data_in0 = word(0);
        ifc.data_in1 = word(1);
        ifc.data_in2 = word(2);
        ifc.data_in3 = word(3);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #3;
        reset_L = 1'b1;
        step();
    endtask

    // Starts in IDLE with the winner known; runs a full burst and its trailing bubble.
    task automatic full_burst(input int lane);
        step();
        check("burst_busy", ifc.busy, 1);
        check("burst_grant", ifc.grant, lane);
        check("burst_bubble_vld", ifc.valid_out_l2, 0);
        for (int w = 0; w < 4; w++) begin
            check("burst_ready", rdy(), 32'(4'b0001 << lane));
            step();
            check("burst_vld", ifc.valid_out_l2, 1);
            check("burst_data", ifc.data_out_l2, word(lane));
        end
        check("burst_idle", ifc.busy, 0);
        check("burst_idle_rdy", rdy(), 0);
    endtask

    initial begin
        set_valid(4'b0000);
        ifc.data_in0 = '0; ifc.data_in1 = '0; ifc.data_in2 = '0; ifc.data_in3 = '0;
        ifc.lane_en  = 4'hF;
        ifc.ready_in = 1'b0;

        // Reset held with inputs toggling
        for (int i = 0; i < 4; i++) begin
            set_valid(4'(i * 5 + 3));
            ifc.data_in0 = 8'(i * 37);
            ifc.ready_in = i[0];
            step();
            check("rst_rdy", rdy(), 0);
            check("rst_vld", ifc.valid_out_l2, 0);
            check("rst_data", ifc.data_out_l2, 0);
            check("rst_grant", ifc.grant, 0);
            check("rst_busy", ifc.busy, 0);
        end
        set_valid(4'b0000);
        ifc.ready_in = 1'b1;
        reset_L = 1'b1;
        step();

        // Single lane latency
        set_valid(4'b0100);
        ifc.data_in2 = 8'hA5;
        step();
        check("single_grant", ifc.grant, 2);
        check("single_busy", ifc.busy, 1);
        check("single_ready", rdy(), 4'b0100);
        check("single_vld_early", ifc.valid_out_l2, 0);
        step();
        check("single_vld", ifc.valid_out_l2, 1);
        check("single_data", ifc.data_out_l2, 8'hA5);
        set_valid(4'b0000);
        step();
        check("single_release", ifc.busy, 0);
        check("single_drain", ifc.valid_out_l2, 0);
        check("single_hold", ifc.data_out_l2, 8'hA5);

        // All lanes valid, fair rotation from lane 0
        do_reset();
        set_words();
        set_valid(4'b1111);
        full_burst(0);
        full_burst(1);
        full_burst(2);
        full_burst(3);
        full_burst(0);
        set_valid(4'b0000);
        step();
        check("rot_stay_idle", ifc.busy, 0);

        // Backpressure on lane 1 (rr_ptr is 1 here)
        ifc.data_in1 = 8'h11;
        set_valid(4'b0010);
        step();
        check("bp_grant", ifc.grant, 1);
        step();
        check("bp_first", ifc.data_out_l2, 8'h11);
        ifc.data_in1 = 8'h22;
        ifc.ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", ifc.ready1, 0);
            step();
            check("bp_data", ifc.data_out_l2, 8'h11);
            check("bp_vld", ifc.valid_out_l2, 1);
            check("bp_cnt", dut.burst_cnt, 1);
        end
        ifc.ready_in = 1'b1;
        #1;
        check("bp_resume_rdy", ifc.ready1, 1);
        step();
        check("bp_resume_data", ifc.data_out_l2, 8'h22);
        check("bp_resume_cnt", dut.burst_cnt, 2);
        set_valid(4'b0000);
        step();
        check("bp_release", ifc.busy, 0);

        // Early release of lane 0 hands over to lane 3
        do_reset();
        set_words();
        set_valid(4'b1001);
        step();
        check("early_grant0", ifc.grant, 0);
        step();
        step();
        check("early_cnt", dut.burst_cnt, 2);
        set_valid(4'b1000);
        step();
        check("early_idle", ifc.busy, 0);
        check("early_no_xfer", ifc.valid_out_l2, 0);
        step();
        check("early_grant3", ifc.grant, 3);
        check("early_ready3", rdy(), 4'b1000);
        set_valid(4'b0000);
        step();
        step();

        // Lane 2 disabled: rotation 0,1,3,0
        do_reset();
        set_words();
        ifc.lane_en = 4'b1011;
        set_valid(4'b1111);
        full_burst(0);
        full_burst(1);
        full_burst(3);
        full_burst(0);
        step();
        check("en_grant1", ifc.grant, 1);
        step();
        check("en_word1", ifc.data_out_l2, word(1));
        ifc.lane_en = 4'b1001;
        #1;
        check("en_drop_rdy", rdy(), 0);
        step();
        check("en_release", ifc.busy, 0);
        check("en_no_xfer", ifc.valid_out_l2, 0);
        step();
        check("en_grant3", ifc.grant, 3);
        step();
        check("en_word3", ifc.data_out_l2, word(3));
        check("en_vld3", ifc.valid_out_l2, 1);

        // Asynchronous reset mid-burst
        #2;
        reset_L = 1'b0;
        #1;
        check("async_vld", ifc.valid_out_l2, 0);
        check("async_busy", ifc.busy, 0);
        check("async_grant", ifc.grant, 0);
        check("async_rdy", rdy(), 0);
        check("async_data", ifc.data_out_l2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
